// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: scans two WIDTH-bit operands from the MSB
// end, DIGIT bits per clock, stopping at the first differing digit. Honours
// an EQ/GT cascade-in so instances chain into wider words, and supports a
// two's-complement mode through a start/busy/done handshake.
module seq_mag_comp #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SGN,
    input  logic             EQ_IN,
    input  logic             GT_IN,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
    logic             sgn_q, sgn_d;
    logic             eqin_q, eqin_d;
    logic             gtin_q, gtin_d;
    logic             done_d, eq_d, gt_d, lt_d;
    logic [WIDTH-1:0] a_cmp, b_cmp;
    logic [DIGIT-1:0] da, db;

    // Signed mode flips the sign bits so an unsigned digit scan orders
    // two's-complement values correctly.
    always_comb begin
        a_cmp            = a_q;
        b_cmp            = b_q;
        a_cmp[WIDTH-1]   = a_q[WIDTH-1] ^ sgn_q;
        b_cmp[WIDTH-1]   = b_q[WIDTH-1] ^ sgn_q;
        da               = a_cmp[idx*DIGIT +: DIGIT];
        db               = b_cmp[idx*DIGIT +: DIGIT];
    end

    // Next-state, datapath and result logic.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        eqin_d  = eqin_q;
        gtin_d  = gtin_q;
        done_d  = 1'b0;
        eq_d    = EQ;
        gt_d    = GT;
        lt_d    = LT;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = SGN;
                    eqin_d  = EQ_IN;
                    gtin_d  = GT_IN;
                    idx_d   = LAST;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!eqin_q) begin
                    // More-significant part already differs: cascade decides.
                    eq_d    = 1'b0;
                    gt_d    = gtin_q;
                    lt_d    = ~gtin_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (da != db) begin
                    eq_d    = 1'b0;
                    gt_d    = (da > db);
                    lt_d    = (da < db);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            eqin_q <= 1'b0;
            gtin_q <= 1'b0;
            done   <= 1'b0;
            EQ     <= 1'b0;
            GT     <= 1'b0;
            LT     <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sgn_q  <= sgn_d;
            eqin_q <= eqin_d;
            gtin_q <= gtin_d;
            done   <= done_d;
            EQ     <= eq_d;
            GT     <= gt_d;
            LT     <= lt_d;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Parametrised, sequential magnitude comparator for two WIDTH-bit operands.
- Scans from the MSB end, DIGIT bits per clock, and stops early at the first differing digit.
- Keeps the EQ/GT cascade-in convention of the slice comparators, so instances chain for wider words.
- Adds a signed (two's-complement) mode and a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per clock; legal values 1, 2, 4, 8. N = WIDTH/DIGIT digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- SGN  input  1  1 = two's-complement compare; sampled with start.
- EQ_IN  input  1  cascade-in "more-significant part equal"; sampled with start.
- GT_IN  input  1  cascade-in "more-significant part greater"; sampled with start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- EQ  output  1  A equals B, cascade included.
- GT  output  1  A greater than B, cascade included.
- LT  output  1  A less than B, cascade included.

Behaviour:
- Reset (rst_n=0, asynchronous): busy=0, done=0, EQ=0, GT=0, LT=0; state=IDLE; digit index and operand registers cleared. Takes effect immediately, including mid-operation; the in-flight comparison is discarded.
- States:
  - IDLE: start=1 at edge k → latch A, B, SGN, EQ_IN, GT_IN; index=N-1; go to RUN; busy=1 from edge k.
  - RUN: each cycle compares the latched digit [index*DIGIT +: DIGIT] of A against B.
  - Resolve at the edge where:
    - the latched EQ_IN=0 (resolves on the first RUN cycle, cascade wins), or
    - the current digits differ, or
    - index=0.
  - Resolve action: register EQ/GT/LT, done=1 for that cycle, busy=0, return to IDLE. Otherwise index decrements.
- Latency: done goes high after edge k+m.
  - m = 1-based position of the first differing digit counting from the MSB digit.
  - m = 1 when the latched EQ_IN=0.
  - m = N when all digits are equal.
- Cascade rules:
  - EQ_IN=0 → GT=GT_IN, LT=~GT_IN, EQ=0; operands are ignored.
  - EQ_IN=1 → GT_IN is ignored.
- Signed mode: for the comparison only, invert bit WIDTH-1 of both latched operands, then compare unsigned.
- Outputs: exactly one of EQ/GT/LT is 1 after the first done. All three hold until the next done or reset; they do not change at start.
- start with busy=1 is ignored; operands are not re-sampled.
- start is accepted in the same cycle done=1 (state is IDLE). A new run begins back-to-back; prior results hold until that run's done.
- A/B/SGN/cascade inputs may change freely after the start edge.
- DIGIT=WIDTH is legal: every comparison takes m=1.

Test Plan:
- WIDTH=8, DIGIT=2, SGN=0, EQ_IN=1, GT_IN=0, A=0xA5, B=0xA5, start pulse → busy=1 for 4 cycles; done after edge k+4; EQ=1, GT=0, LT=0.
- A=0xC0, B=0x40, SGN=0 → done after edge k+1, GT=1. Repeat with SGN=1 → done after edge k+1, LT=1 (−64 < 64).
- A=0x13, B=0x12, SGN=0 → done after edge k+4, GT=1. A=0x12, B=0x13 → done after edge k+4, LT=1.
- EQ_IN=0, GT_IN=1, A=0x00, B=0xFF → done after edge k+1, GT=1, EQ=0, LT=0. EQ_IN=0, GT_IN=0 → LT=1.
- Start A=0xA5=B; pulse start again at edge k+2 with A=0x00 → ignored; the first run completes with EQ=1 after edge k+4. Then rst_n low mid-run → busy, done, EQ, GT, LT all 0 immediately; a new start afterwards completes normally.
- Two back-to-back runs, the second start asserted in the done cycle of the first → second run's busy has no idle gap; each done pulse carries the correct result. Then a randomized sweep against a reference comparison for WIDTH=32 with DIGIT=1, 4 and 8, SGN in {0, 1}.
